ram_port_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two requesters.
  - Master 0 (M0): memory-stage load/store path.
  - Master 1 (M1): secondary master, e.g. instruction fetch or debug/loader.
- Grants at most one access per cycle and drives the RAM strobes from the granted master.
- Routes the 1-cycle-latency read data back to the master that issued the read.
- Gives each master a stall indication so the pipeline can hold.

---
 rtl/ram_port_arbiter_pkg.sv | 20 ++
 rtl/ram_port_arbiter_if.sv | 54 +++++
 rtl/ram_arb_starve_cnt.sv | 34 +++
 rtl/ram_port_arbiter.sv | 115 +++++++++++
 tb/tb_ram_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: master IDs, RAM strobe constants and default tuning for the RAM port arbiter.
// Latency: none; this package holds only declarations.
// Backpressure: none; this package holds only declarations.
package ram_port_arbiter_pkg;

  // Identifies which master a registered read response belongs to.
  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_id_t;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // Number of consecutive denied M1 cycles before M1 is forced through.
  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: bundles both master ports and the RAM port of the arbiter.
// Latency: none; this file only carries the wires.
// Backpressure: mX_stall / mX_gnt tell a requester to hold its fields.
// Modports: master = requester/RAM side (drives mX_* requests and ram_rdata);
//           slave  = arbiter side (drives grants, stalls, responses and ram_* strobes).
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_W-1:0]     m0_addr;
  logic [DATA_W/8-1:0]   m0_sel;
  logic [DATA_W-1:0]     m0_wdata;
  logic                  m0_gnt;
  logic                  m0_stall;
  logic                  m0_rvalid;
  logic [DATA_W-1:0]     m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_W-1:0]     m1_addr;
  logic [DATA_W/8-1:0]   m1_sel;
  logic [DATA_W-1:0]     m1_wdata;
  logic                  m1_gnt;
  logic                  m1_stall;
  logic                  m1_rvalid;
  logic [DATA_W-1:0]     m1_rdata;

  logic                  ram_ce;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W/8-1:0]   ram_sel;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    input  m0_gnt, m0_stall, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
    input  m1_gnt, m1_stall, m1_rvalid, m1_rdata,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    output m0_gnt, m0_stall, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
    output m1_gnt, m1_stall, m1_rvalid, m1_rdata,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/ram_arb_starve_cnt.sv
// ram_arb_starve_cnt: counts consecutive denied M1 cycles and raises force_m1 at the limit.
// Latency: force_m1 is combinational from the registered count and the live m1_req.
// Backpressure: none of its own; it only reorders priority inside the arbiter.
// Ports: clk, rst (sync, active-high), m1_req, m1_gnt in; force_m1 out.
module ram_arb_starve_cnt
  import ram_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic force_m1
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  // Saturates at the limit so a reset-held or otherwise blocked M1 never wraps around.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!m1_req || m1_gnt) begin
      cnt <= '0;
    end else if (cnt != CNT_LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_m1 = m1_req && (cnt == CNT_LIMIT);

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between M0 (priority) and M1.
// Latency: grant is combinational; read data returns to the issuing master 1 cycle after grant.
// Backpressure: a denied requester sees mX_stall = 1 and holds its fields until mX_gnt.
// Ports: clk, rst (sync, active-high); bus (slave modport): m0_*/m1_* requests, grants,
//        stalls and read responses, ram_* strobes towards the RAM, ram_rdata back from it.
// Option: define RAM_ARB_STARVE_GUARD_EN to force M1 through after STARVE_MAX denials.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);
  localparam int SEL_W = DATA_W / 8;

  if (STARVE_MAX < 1) begin : g_bad_cfg
    $error("ram_port_arbiter: STARVE_MAX must be at least 1");
  end

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              force_m1;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [SEL_W-1:0]  g_sel;
  logic [DATA_W-1:0] g_wdata;
  logic              resp_valid;
  arb_id_t           resp_id;
  logic              m0_rvalid;
  logic              m1_rvalid;

`ifdef RAM_ARB_STARVE_GUARD_EN
  ram_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .m1_req   (bus.m1_req),
    .m1_gnt   (gnt1),
    .force_m1 (force_m1)
  );
`else
  assign force_m1 = 1'b0;
`endif

  // force_m1 already implies m1_req, so it can override M0 directly.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (force_m1) begin
        gnt1 = 1'b1;
      end else if (bus.m0_req) begin
        gnt0 = 1'b1;
      end else if (bus.m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;

  // RAM strobes are zeroed on idle cycles so nothing stale reaches the RAM pins.
  always_comb begin
    g_we    = WRITE_DISABLE;
    g_addr  = '0;
    g_sel   = '0;
    g_wdata = '0;
    if (gnt0) begin
      g_we    = bus.m0_we;
      g_addr  = bus.m0_addr;
      g_sel   = bus.m0_sel;
      g_wdata = bus.m0_wdata;
    end else if (gnt1) begin
      g_we    = bus.m1_we;
      g_addr  = bus.m1_addr;
      g_sel   = bus.m1_sel;
      g_wdata = bus.m1_wdata;
    end
  end

  assign bus.ram_ce    = any_gnt ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.ram_we    = g_we;
  assign bus.ram_addr  = g_addr;
  assign bus.ram_sel   = g_sel;
  assign bus.ram_wdata = g_wdata;

  // Remembers who issued the read so the next-cycle RAM data is steered to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= ARB_M0;
    end else begin
      resp_valid <= any_gnt & ~g_we;
      resp_id    <= gnt1 ? ARB_M1 : ARB_M0;
    end
  end

  // Gating with rst drops a response whose grant edge was just before reset rose.
  assign m0_rvalid = resp_valid & ~rst & (resp_id == ARB_M0);
  assign m1_rvalid = resp_valid & ~rst & (resp_id == ARB_M1);

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_stall  = bus.m0_req & ~gnt0 & ~rst;
  assign bus.m1_stall  = bus.m1_req & ~gnt1 & ~rst;
  assign bus.m0_rvalid = m0_rvalid;
  assign bus.m1_rvalid = m1_rvalid;
  assign bus.m0_rdata  = m0_rvalid ? bus.ram_rdata : '0;
  assign bus.m1_rdata  = m1_rvalid ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: drives directed and random traffic into ram_port_arbiter with a RAM model.
// Latency: expected outputs come from a transaction-level model of grants and pending reads.
// Backpressure: bench requesters hold their fields until granted, occasionally cancelling M1.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SMAX   = 4;
`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM environment: 16 words, word index from addr[5:2], 1-cycle read latency.
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    bus.ram_rdata <= '0;
  end
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_sel[b]) mem[bus.ram_addr[5:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end else begin
        bus.ram_rdata <= mem[bus.ram_addr[5:2]];
      end
    end
  end

  // Reference model: priority rule, M1 wait count, shadow memory and the one pending read.
  logic [31:0] shadow [16];
  logic        pend_vld;
  logic        pend_id;
  logic [31:0] pend_dat;
  int          m1_wait;
  initial begin
    pend_vld = 1'b0;
    pend_id  = 1'b0;
    pend_dat = '0;
    m1_wait  = 0;
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
  end

  always @(negedge clk) begin : cmp
    logic        e0, e1, ewe, ev0, ev1;
    logic [31:0] eaddr, ewd;
    logic [3:0]  esel;
    int          idx;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst) begin
      if (GUARD && bus.m1_req && m1_wait == SMAX) e1 = 1'b1;
      else if (bus.m0_req) e0 = 1'b1;
      else if (bus.m1_req) e1 = 1'b1;
    end
    ewe   = e0 ? bus.m0_we    : (e1 ? bus.m1_we    : 1'b0);
    eaddr = e0 ? bus.m0_addr  : (e1 ? bus.m1_addr  : 32'h0);
    esel  = e0 ? bus.m0_sel   : (e1 ? bus.m1_sel   : 4'h0);
    ewd   = e0 ? bus.m0_wdata : (e1 ? bus.m1_wdata : 32'h0);
    ev0   = !rst && pend_vld && !pend_id;
    ev1   = !rst && pend_vld && pend_id;

    chk("m0_gnt",    64'(bus.m0_gnt),    64'(e0));
    chk("m1_gnt",    64'(bus.m1_gnt),    64'(e1));
    chk("m0_stall",  64'(bus.m0_stall),  64'(bus.m0_req && !e0 && !rst));
    chk("m1_stall",  64'(bus.m1_stall),  64'(bus.m1_req && !e1 && !rst));
    chk("ram_ce",    64'(bus.ram_ce),    64'(e0 || e1));
    chk("ram_we",    64'(bus.ram_we),    64'(ewe));
    chk("ram_addr",  64'(bus.ram_addr),  64'(eaddr));
    chk("ram_sel",   64'(bus.ram_sel),   64'(esel));
    chk("ram_wdata", 64'(bus.ram_wdata), 64'(ewd));
    chk("m0_rvalid", 64'(bus.m0_rvalid), 64'(ev0));
    chk("m1_rvalid", 64'(bus.m1_rvalid), 64'(ev1));
    chk("m0_rdata",  64'(bus.m0_rdata),  64'(ev0 ? pend_dat : 32'h0));
    chk("m1_rdata",  64'(bus.m1_rdata),  64'(ev1 ? pend_dat : 32'h0));

    if (rst) begin
      pend_vld = 1'b0;
      m1_wait  = 0;
    end else begin
      idx      = int'(eaddr[5:2]);
      pend_vld = (e0 || e1) && !ewe;
      pend_id  = e1;
      pend_dat = shadow[idx];
      if ((e0 || e1) && ewe)
        for (int b = 0; b < 4; b++)
          if (esel[b]) shadow[idx][8*b +: 8] = ewd[8*b +: 8];
      m1_wait = (bus.m1_req && !e1) ? m1_wait + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_sel = sel; bus.m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_sel = sel; bus.m1_wdata = wd;
  endtask

  initial begin
    int   first1;
    logic stall_at;
    logic g0, g1;

    // Reset held with both masters requesting.
    rst = 1'b1;
    set_m0(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    set_m1(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    repeat (3) begin
      samp();
      chk("rst_m0_gnt", 64'(bus.m0_gnt), 64'd0);
      chk("rst_ram_ce", 64'(bus.ram_ce), 64'd0);
      chk("rst_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
    end
    tick(); rst = 1'b0;
    samp();
    chk("rel_m0_gnt", 64'(bus.m0_gnt), 64'd1);
    chk("rel_m1_stall", 64'(bus.m1_stall), 64'd1);

    // M0 read of 0x10.
    tick(); set_m0(1'b1, 1'b0, 32'h10, 4'hF, 32'h0); set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    samp();
    chk("rd_ram_ce", 64'(bus.ram_ce), 64'd1);
    chk("rd_ram_we", 64'(bus.ram_we), 64'd0);
    tick(); set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    samp();
    chk("rd_m0_rvalid", 64'(bus.m0_rvalid), 64'd1);
    chk("rd_m0_rdata", 64'(bus.m0_rdata), 64'hDEADBEEF);
    chk("rd_m1_rvalid", 64'(bus.m1_rvalid), 64'd0);

    // Colliding M0 write and M1 read.
    tick(); set_m0(1'b1, 1'b1, 32'h20, 4'b0011, 32'h12345678); set_m1(1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
    samp();
    chk("col_m0_gnt", 64'(bus.m0_gnt), 64'd1);
    chk("col_m1_stall", 64'(bus.m1_stall), 64'd1);
    tick(); set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    samp();
    chk("col_m1_gnt", 64'(bus.m1_gnt), 64'd1);
    chk("col_m0_norv", 64'(bus.m0_rvalid), 64'd0);
    tick(); set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    samp();
    chk("col_m1_rvalid", 64'(bus.m1_rvalid), 64'd1);
    chk("col_m1_rdata", 64'(bus.m1_rdata), 64'hC0DE0009);
    tick(); set_m0(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    samp();
    tick(); set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    samp();
    chk("merge_rdata", 64'(bus.m0_rdata), 64'hC0DE5678);

    // Alternating M0/M1 reads on consecutive cycles.
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4 && (k % 2) == 0) begin
        set_m0(1'b1, 1'b0, 32'(k * 4), 4'hF, 32'h0); set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end else if (k < 4) begin
        set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_m1(1'b1, 1'b0, 32'(k * 4 + 32'h30), 4'hF, 32'h0);
      end else begin
        set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
      samp();
      if (k < 4) chk("alt_gnt", 64'(((k % 2) == 0) ? bus.m0_gnt : bus.m1_gnt), 64'd1);
      if (k >= 1) chk("alt_rvalid", 64'((((k - 1) % 2) == 0) ? bus.m0_rvalid : bus.m1_rvalid), 64'd1);
    end

    // M0 hogging the port while M1 waits.
    first1   = -1;
    stall_at = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      set_m0(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      if (first1 < 0) set_m1(1'b1, 1'b0, 32'h3C, 4'hF, 32'h0);
      else            set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      samp();
      if (bus.m1_gnt && first1 < 0) begin
        first1   = c;
        stall_at = bus.m0_stall;
      end
    end
`ifdef RAM_ARB_STARVE_GUARD_EN
    chk("starve_first_m1", 64'(first1), 64'd4);
    chk("starve_m0_stall", 64'(stall_at), 64'd1);
`else
    chk("starve_m1_never", 64'(first1), 64'(-1));
`endif

    // M1 read granted, then reset the following cycle.
    tick(); set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_m1(1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
    samp();
    chk("rr_m1_gnt", 64'(bus.m1_gnt), 64'd1);
    tick(); rst = 1'b1; set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    samp();
    chk("rr_m1_rvalid_rst", 64'(bus.m1_rvalid), 64'd0);
    tick(); samp();
    tick(); rst = 1'b0;
    samp();
    chk("rr_m1_rvalid_rel", 64'(bus.m1_rvalid), 64'd0);
    chk("rr_m1_rdata_rel", 64'(bus.m1_rdata), 64'd0);

    // Random traffic with occasional reset pulses and M1 cancels.
    g0 = 1'b0;
    g1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if (!bus.m0_req || g0) begin
        if ($urandom_range(0, 3) != 0)
          set_m0(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, 4'($urandom), $urandom);
        else
          set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
      if (!bus.m1_req || g1) begin
        if ($urandom_range(0, 1) != 0)
          set_m1(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, 4'($urandom), $urandom);
        else
          set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end else if ($urandom_range(0, 15) == 0) begin
        set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
      samp();
      g0 = bus.m0_gnt;
      g1 = bus.m1_gnt;
    end

    tick();
    rst = 1'b0;
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    samp();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
